ecg_layer_sequencer: RTL and testbench

//  Master sequencer for the ECG accelerator. Steps one inference through ECG load, per-layer parameter fetch
//  and per-layer multi-tile weight-fetch/compute loops. Sits between SPI, MemCtrl and the PE array.

---
 rtl/ecg_layer_sequencer.sv | 141 ++++++++++++++
 tb/tb_ecg_layer_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_layer_sequencer.sv
// ecg_layer_sequencer: master sequencer stepping one ECG inference through load, per-layer param fetch and tile loops
// Ports: clk_cal/rst_cal_n clock and async active-low reset; cfg_we/cfg_addr/cfg_wdata config writes
//   (accepted in IDLE/FT_ADDR only); mode_cont, abort and done handshakes from SPI/MemCtrl/PE array;
//   mc_cs/or_cs one-hot states, layer_idx/tile_idx, snapshot ecg_saddr/wt_saddr/param_saddr/ecg_len,
//   busy, inf_done pulse, sticky err_timeout.
module ecg_layer_sequencer #(
  parameter int AW      = 32,
  parameter int LCNT_W  = 4,
  parameter int NT_W    = 8,
  parameter int LEN_W   = 12,
  parameter int TO_W    = 16,
  parameter int DEF_LYR = 9,
  parameter int DEF_LEN = 3600
) (
  input  logic              clk_cal,
  input  logic              rst_cal_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [AW-1:0]     cfg_wdata,
  input  logic              mode_cont,
  input  logic              abort,
  input  logic              memct_init_cmplt,
  input  logic              spi_start,
  input  logic              spi_done,
  input  logic              ft_ecg_done,
  input  logic              ft_lyr_param_done,
  input  logic [NT_W-1:0]   lyr_nt_num,
  input  logic              ft_wt_done,
  input  logic              tile_cal_done,
  output logic [7:0]        mc_cs,
  output logic [3:0]        or_cs,
  output logic [LCNT_W-1:0] layer_idx,
  output logic [NT_W-1:0]   tile_idx,
  output logic [AW-1:0]     ecg_saddr,
  output logic [AW-1:0]     wt_saddr,
  output logic [AW-1:0]     param_saddr,
  output logic [LEN_W-1:0]  ecg_len,
  output logic              busy,
  output logic              inf_done,
  output logic              err_timeout
);
  typedef enum logic [7:0] {
    IDLE = 8'h01, FT_ADDR = 8'h02, ECG_UD = 8'h04, FT_ECG = 8'h08,
    FT_PARA = 8'h10, CONV_CAL = 8'h20, LY_DONE = 8'h40, INF_DONE = 8'h80
  } mc_t;
  typedef enum logic [3:0] {OR_IDLE = 4'h1, OR_FT_WT = 4'h2, OR_CAL = 4'h4, OR_DONE = 4'h8} or_t;
  mc_t mc_q, mc_d;
  or_t or_q, or_d;
  logic [AW-1:0] cfg_ecg, cfg_wt, cfg_param;
  logic [LCNT_W-1:0] cfg_nl, eff_layers;
  logic [LEN_W-1:0] cfg_len;
  logic [TO_W-1:0] cfg_to, wd_cnt;
  logic [NT_W-1:0] nt_q;
  logic last_tile, lyr_done, wd_run, wd_to, kill, cfg_ok, snap;
  assign eff_layers = cfg_nl == '0 ? LCNT_W'(1) : cfg_nl;
  assign last_tile = tile_idx == nt_q - NT_W'(1);
  assign lyr_done = or_q == OR_CAL && tile_cal_done && last_tile;
  assign wd_run = mc_q inside {FT_ECG, FT_PARA, CONV_CAL};
  assign wd_to = wd_run && cfg_to != '0 && wd_cnt == cfg_to;
  // watchdog expiry is treated exactly like the abort pin
  assign kill = abort | wd_to;
  assign cfg_ok = mc_q inside {IDLE, FT_ADDR};
  assign snap = mc_q == FT_ADDR && mc_d == ECG_UD;
  assign mc_cs = mc_q;
  assign or_cs = or_q;
  assign busy = mc_q inside {FT_ECG, FT_PARA, CONV_CAL, LY_DONE};
  assign inf_done = mc_q == INF_DONE;
  always_comb begin
    mc_d = mc_q;
    or_d = or_q;
    case (mc_q)
      IDLE:     mc_d = memct_init_cmplt ? FT_ADDR : IDLE;
      FT_ADDR:  mc_d = spi_start ? ECG_UD : FT_ADDR;
      ECG_UD:   mc_d = spi_done ? FT_ECG : ECG_UD;
      FT_ECG:   mc_d = ft_ecg_done ? FT_PARA : FT_ECG;
      FT_PARA:  mc_d = ft_lyr_param_done ? CONV_CAL : FT_PARA;
      CONV_CAL: mc_d = lyr_done ? LY_DONE : CONV_CAL;
      LY_DONE:  mc_d = layer_idx == eff_layers ? INF_DONE : FT_PARA;
      INF_DONE: mc_d = mode_cont ? FT_ADDR : IDLE;
      default:  mc_d = IDLE;
    endcase
    case (or_q)
      OR_IDLE:  or_d = mc_q == CONV_CAL ? OR_FT_WT : OR_IDLE;
      OR_FT_WT: or_d = ft_wt_done ? OR_CAL : OR_FT_WT;
      OR_CAL:   or_d = tile_cal_done ? (last_tile ? OR_DONE : OR_FT_WT) : OR_CAL;
      OR_DONE:  or_d = OR_IDLE;
      default:  or_d = OR_IDLE;
    endcase
    if (kill) begin
      mc_d = IDLE;
      or_d = OR_IDLE;
    end
  end
  always_ff @(posedge clk_cal or negedge rst_cal_n)
    if (!rst_cal_n) begin
      mc_q <= IDLE;
      or_q <= OR_IDLE;
      layer_idx <= '0;
      tile_idx <= '0;
      nt_q <= NT_W'(1);
      wd_cnt <= '0;
      err_timeout <= 1'b0;
      cfg_ecg <= '0;
      cfg_wt <= '0;
      cfg_param <= '0;
      cfg_nl <= LCNT_W'(DEF_LYR);
      cfg_len <= LEN_W'(DEF_LEN);
      cfg_to <= '0;
      ecg_saddr <= '0;
      wt_saddr <= '0;
      param_saddr <= '0;
      ecg_len <= '0;
    end else begin
      mc_q <= mc_d;
      or_q <= or_d;
      layer_idx <= mc_d == IDLE ? '0 :
                   mc_q == FT_ECG && mc_d == FT_PARA ? LCNT_W'(1) :
                   mc_q == LY_DONE && mc_d == FT_PARA ? layer_idx + LCNT_W'(1) : layer_idx;
      tile_idx <= kill || (or_q == OR_IDLE && or_d == OR_FT_WT) ? '0 :
                  or_q == OR_CAL && or_d == OR_FT_WT ? tile_idx + NT_W'(1) : tile_idx;
      nt_q <= mc_q == FT_PARA && mc_d == CONV_CAL ? (lyr_nt_num == '0 ? NT_W'(1) : lyr_nt_num) : nt_q;
      wd_cnt <= !wd_run || mc_d != mc_q || or_d != or_q ? '0 : wd_cnt + TO_W'(1);
      err_timeout <= wd_to ? 1'b1 : snap ? 1'b0 : err_timeout;
      if (cfg_we && cfg_ok)
        case (cfg_addr)
          3'd0:    cfg_ecg <= cfg_wdata;
          3'd1:    cfg_wt <= cfg_wdata;
          3'd2:    cfg_param <= cfg_wdata;
          3'd3:    cfg_nl <= cfg_wdata[LCNT_W-1:0];
          3'd4:    cfg_len <= cfg_wdata[LEN_W-1:0];
          3'd5:    cfg_to <= cfg_wdata[TO_W-1:0];
          default: ;
        endcase
      if (snap) begin
        ecg_saddr <= cfg_ecg;
        wt_saddr <= cfg_wt;
        param_saddr <= cfg_param;
        ecg_len <= cfg_len;
      end
    end
endmodule

// File: tb/tb_ecg_layer_sequencer.sv
// tb_ecg_layer_sequencer: directed vector table plus reactive multi-cycle sequences for ecg_layer_sequencer
module tb_ecg_layer_sequencer;
  localparam logic [7:0] M_IDLE = 8'h01, M_FTA = 8'h02, M_UD = 8'h04, M_FE = 8'h08,
                         M_FP = 8'h10, M_CC = 8'h20, M_LD = 8'h40, M_INF = 8'h80;
  localparam logic [3:0] O_IDLE = 4'h1, O_WT = 4'h2, O_CAL = 4'h4, O_DN = 4'h8;
  localparam logic [7:0] I_INIT = 8'h01, I_SS = 8'h02, I_SD = 8'h04, I_ED = 8'h08,
                         I_PD = 8'h10, I_WD = 8'h20, I_CD = 8'h40;
  typedef struct {
    logic [7:0] in;
    logic [7:0] nt;
    logic [7:0] mc;
    logic [3:0] orc;
    logic [3:0] ly;
    logic [7:0] ti;
    logic       inf;
  } vec_t;
  logic clk_cal = 1'b0, rst_cal_n = 1'b0;
  logic cfg_we = 1'b0, mode_cont = 1'b0, abort = 1'b0, memct_init_cmplt = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic spi_start = 1'b0, spi_done = 1'b0, ft_ecg_done = 1'b0, ft_lyr_param_done = 1'b0;
  logic ft_wt_done = 1'b0, tile_cal_done = 1'b0;
  logic [7:0] lyr_nt_num = '0;
  logic [7:0] mc_cs;
  logic [3:0] or_cs;
  logic [3:0] layer_idx;
  logic [7:0] tile_idx;
  logic [31:0] ecg_saddr, wt_saddr, param_saddr;
  logic [11:0] ecg_len;
  logic busy, inf_done, err_timeout;
  int total = 0, bad = 0;
  vec_t v[21];
  always #5 clk_cal = ~clk_cal;
  ecg_layer_sequencer dut (
    .clk_cal(clk_cal), .rst_cal_n(rst_cal_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .mode_cont(mode_cont), .abort(abort),
    .memct_init_cmplt(memct_init_cmplt), .spi_start(spi_start), .spi_done(spi_done),
    .ft_ecg_done(ft_ecg_done), .ft_lyr_param_done(ft_lyr_param_done), .lyr_nt_num(lyr_nt_num),
    .ft_wt_done(ft_wt_done), .tile_cal_done(tile_cal_done), .mc_cs(mc_cs), .or_cs(or_cs),
    .layer_idx(layer_idx), .tile_idx(tile_idx), .ecg_saddr(ecg_saddr), .wt_saddr(wt_saddr),
    .param_saddr(param_saddr), .ecg_len(ecg_len), .busy(busy), .inf_done(inf_done),
    .err_timeout(err_timeout)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_cal);
    #1;
  endtask
  task automatic clr();
    cfg_we = 1'b0;
    abort = 1'b0;
    spi_start = 1'b0;
    spi_done = 1'b0;
    ft_ecg_done = 1'b0;
    ft_lyr_param_done = 1'b0;
    ft_wt_done = 1'b0;
    tile_cal_done = 1'b0;
  endtask
  task automatic do_reset();
    clr();
    memct_init_cmplt = 1'b0;
    mode_cont = 1'b0;
    rst_cal_n = 1'b0;
    repeat (2) step();
    rst_cal_n = 1'b1;
    step();
  endtask
  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask
  task automatic drive(input logic [7:0] nt);
    memct_init_cmplt = 1'b1;
    spi_start = mc_cs == M_FTA;
    spi_done = mc_cs == M_UD;
    ft_ecg_done = mc_cs == M_FE;
    ft_lyr_param_done = mc_cs == M_FP;
    lyr_nt_num = nt;
    ft_wt_done = or_cs == O_WT;
    tile_cal_done = or_cs == O_CAL;
  endtask
  task automatic go_to(input string nm, input logic [7:0] tm, input logic [3:0] to, input logic [7:0] nt);
    for (int c = 0; c < 60 && !(mc_cs == tm && or_cs == to); c++) begin
      drive(nt);
      step();
      clr();
    end
    chk({nm, "_reach"}, {20'd0, or_cs, mc_cs}, {20'd0, to, tm});
  endtask
  task automatic run(input logic [7:0] nt, input int want, output int ly, output int inf,
                     output int wt, output int tmax, output int seq_bad);
    int lcur;
    ly = 0; inf = 0; wt = 0; tmax = 0; seq_bad = 0; lcur = 0;
    for (int c = 0; c < 3000 && inf < want; c++) begin
      drive(nt);
      if (ft_wt_done) wt++;
      step();
      clr();
      if (mc_cs == M_LD) begin
        ly++;
        lcur++;
        if (int'(layer_idx) != lcur) seq_bad++;
      end
      if (inf_done) begin
        inf++;
        lcur = 0;
      end
      if (int'(tile_idx) > tmax) tmax = int'(tile_idx);
    end
  endtask
  initial begin
    int ly, inf, wt, tmax, sb, inf_tot;
    bit hit;
    v[0]  = '{I_INIT,        8'd0, M_FTA, O_IDLE, 4'd0, 8'd0, 1'b0};
    v[1]  = '{I_INIT | I_SD, 8'd0, M_FTA, O_IDLE, 4'd0, 8'd0, 1'b0};
    v[2]  = '{I_SS,          8'd0, M_UD,  O_IDLE, 4'd0, 8'd0, 1'b0};
    v[3]  = '{I_ED,          8'd0, M_UD,  O_IDLE, 4'd0, 8'd0, 1'b0};
    v[4]  = '{I_SD,          8'd0, M_FE,  O_IDLE, 4'd0, 8'd0, 1'b0};
    v[5]  = '{8'h00,         8'd0, M_FE,  O_IDLE, 4'd0, 8'd0, 1'b0};
    v[6]  = '{I_ED,          8'd0, M_FP,  O_IDLE, 4'd1, 8'd0, 1'b0};
    v[7]  = '{I_PD,          8'd2, M_CC,  O_IDLE, 4'd1, 8'd0, 1'b0};
    v[8]  = '{8'h00,         8'd0, M_CC,  O_WT,   4'd1, 8'd0, 1'b0};
    v[9]  = '{I_CD,          8'd0, M_CC,  O_WT,   4'd1, 8'd0, 1'b0};
    v[10] = '{I_WD,          8'd0, M_CC,  O_CAL,  4'd1, 8'd0, 1'b0};
    v[11] = '{I_CD,          8'd0, M_CC,  O_WT,   4'd1, 8'd1, 1'b0};
    v[12] = '{I_WD,          8'd0, M_CC,  O_CAL,  4'd1, 8'd1, 1'b0};
    v[13] = '{I_CD,          8'd0, M_LD,  O_DN,   4'd1, 8'd1, 1'b0};
    v[14] = '{8'h00,         8'd0, M_FP,  O_IDLE, 4'd2, 8'd1, 1'b0};
    v[15] = '{I_PD,          8'd0, M_CC,  O_IDLE, 4'd2, 8'd1, 1'b0};
    v[16] = '{8'h00,         8'd0, M_CC,  O_WT,   4'd2, 8'd0, 1'b0};
    v[17] = '{I_WD,          8'd0, M_CC,  O_CAL,  4'd2, 8'd0, 1'b0};
    v[18] = '{I_CD,          8'd0, M_LD,  O_DN,   4'd2, 8'd0, 1'b0};
    v[19] = '{8'h00,         8'd0, M_INF, O_IDLE, 4'd2, 8'd0, 1'b1};
    v[20] = '{8'h00,         8'd0, M_IDLE, O_IDLE, 4'd0, 8'd0, 1'b0};
    do_reset();
    chk("rst_mc", 32'(mc_cs), 32'(M_IDLE));
    chk("rst_or", 32'(or_cs), 32'(O_IDLE));
    chk("rst_layer", 32'(layer_idx), 0);
    chk("rst_tile", 32'(tile_idx), 0);
    chk("rst_ecg_saddr", ecg_saddr, 0);
    chk("rst_ecg_len", 32'(ecg_len), 0);
    chk("rst_flags", {29'd0, busy, inf_done, err_timeout}, 0);
    cfg(3'd3, 32'd2);
    cfg(3'd0, 32'h1000_0000);
    cfg(3'd1, 32'h2000_0000);
    cfg(3'd2, 32'h3000_0040);
    chk("cfg_idle_mc", 32'(mc_cs), 32'(M_IDLE));
    for (int i = 0; i < 21; i++) begin
      memct_init_cmplt = v[i].in[0];
      spi_start = v[i].in[1];
      spi_done = v[i].in[2];
      ft_ecg_done = v[i].in[3];
      ft_lyr_param_done = v[i].in[4];
      ft_wt_done = v[i].in[5];
      tile_cal_done = v[i].in[6];
      lyr_nt_num = v[i].nt;
      step();
      clr();
      chk($sformatf("vec%0d_mc", i), 32'(mc_cs), 32'(v[i].mc));
      chk($sformatf("vec%0d_or", i), 32'(or_cs), 32'(v[i].orc));
      chk($sformatf("vec%0d_layer", i), 32'(layer_idx), 32'(v[i].ly));
      chk($sformatf("vec%0d_tile", i), 32'(tile_idx), 32'(v[i].ti));
      chk($sformatf("vec%0d_inf", i), 32'(inf_done), 32'(v[i].inf));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(|v[i].mc[6:3]));
    end
    chk("snap_ecg_saddr", ecg_saddr, 32'h1000_0000);
    chk("snap_wt_saddr", wt_saddr, 32'h2000_0000);
    chk("snap_param_saddr", param_saddr, 32'h3000_0040);
    chk("snap_ecg_len", 32'(ecg_len), 3600);
    // defaults: nine layers of one tile each
    do_reset();
    run(8'd0, 1, ly, inf, wt, tmax, sb);
    chk("def_ly_done", ly, 9);
    chk("def_inf", inf, 1);
    chk("def_wt", wt, 9);
    chk("def_layer_seq", sb, 0);
    step();
    chk("def_end_mc", 32'(mc_cs), 32'(M_IDLE));
    chk("def_end_layer", 32'(layer_idx), 0);
    // three layers of four tiles
    do_reset();
    cfg(3'd3, 32'd3);
    run(8'd4, 1, ly, inf, wt, tmax, sb);
    chk("l3_ly_done", ly, 3);
    chk("l3_wt", wt, 12);
    chk("l3_tmax", tmax, 3);
    chk("l3_inf", inf, 1);
    chk("l3_layer_seq", sb, 0);
    // continuous mode: two windows back to back
    do_reset();
    cfg(3'd3, 32'd1);
    mode_cont = 1'b1;
    run(8'd1, 1, ly, inf, wt, tmax, sb);
    inf_tot = inf;
    step();
    chk("cont_back_fta", 32'(mc_cs), 32'(M_FTA));
    run(8'd1, 1, ly, inf, wt, tmax, sb);
    inf_tot += inf;
    chk("cont_inf_total", inf_tot, 2);
    mode_cont = 1'b0;
    step();
    chk("cont_end_idle", 32'(mc_cs), 32'(M_IDLE));
    // config writes outside IDLE/FT_ADDR are dropped
    do_reset();
    go_to("len_cc", M_CC, O_IDLE, 8'd1);
    cfg(3'd4, 32'd1000);
    chk("len_cc_snap", 32'(ecg_len), 3600);
    abort = 1'b1;
    step();
    clr();
    chk("abort_mc", 32'(mc_cs), 32'(M_IDLE));
    chk("abort_or", 32'(or_cs), 32'(O_IDLE));
    chk("abort_idx", {24'd0, layer_idx, tile_idx[3:0]}, 0);
    chk("abort_len_hold", 32'(ecg_len), 3600);
    go_to("len_ud1", M_UD, O_IDLE, 8'd1);
    chk("len_ignored", 32'(ecg_len), 3600);
    abort = 1'b1;
    step();
    clr();
    go_to("len_fta", M_FTA, O_IDLE, 8'd1);
    cfg(3'd4, 32'd1000);
    chk("len_pre_snap", 32'(ecg_len), 3600);
    go_to("len_ud2", M_UD, O_IDLE, 8'd1);
    chk("len_written", 32'(ecg_len), 1000);
    // watchdog with tile_cal_done withheld
    do_reset();
    cfg(3'd5, 32'd50);
    go_to("wd", M_CC, O_CAL, 8'd1);
    repeat (45) step();
    chk("wd_not_yet", {23'd0, err_timeout, mc_cs}, {23'd0, 1'b0, M_CC});
    hit = 1'b0;
    for (int c = 0; c < 11 && !hit; c++) begin
      step();
      hit = err_timeout;
    end
    chk("wd_err", 32'(err_timeout), 1);
    chk("wd_mc", 32'(mc_cs), 32'(M_IDLE));
    chk("wd_or", 32'(or_cs), 32'(O_IDLE));
    chk("wd_layer", 32'(layer_idx), 0);
    go_to("wd_fta", M_FTA, O_IDLE, 8'd1);
    chk("wd_err_held", 32'(err_timeout), 1);
    spi_start = 1'b1;
    step();
    clr();
    chk("wd_err_clr", {23'd0, err_timeout, mc_cs}, {23'd0, 1'b0, M_UD});
    // abort racing the final tile_cal_done
    do_reset();
    go_to("ab", M_CC, O_CAL, 8'd0);
    tile_cal_done = 1'b1;
    abort = 1'b1;
    step();
    clr();
    memct_init_cmplt = 1'b0;
    chk("ab_mc", 32'(mc_cs), 32'(M_IDLE));
    chk("ab_or", 32'(or_cs), 32'(O_IDLE));
    chk("ab_idx", {24'd0, layer_idx, tile_idx[3:0]}, 0);
    inf = 0;
    for (int c = 0; c < 4; c++) begin
      if (inf_done || mc_cs != M_IDLE) inf++;
      step();
    end
    chk("ab_quiet", inf, 0);
    // zero layer count and zero tile count both act as one
    cfg(3'd3, 32'd0);
    run(8'd0, 1, ly, inf, wt, tmax, sb);
    chk("z_ly_done", ly, 1);
    chk("z_wt", wt, 1);
    chk("z_inf", inf, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
